ram_arbiter: RTL and testbench

- Shares the single-port 256x8 data RAM between two requesters.
- Requester A is the CPU data path (load/store port); requester B is a secondary master (debug loader or DMA).
- Uses fixed priority to A, with a starvation guard that forces a B grant after B has waited STARVE_MAX cycles.
- Sits between the requesters and the lpm_ram_256_8 instance; the CPU stalls on A until a_ack.

---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/ram_arb_starve.sv | 41 ++++
 rtl/ram_arbiter.sv | 137 +++++++++++++
 tb/tb_ram_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared state and owner encodings for the RAM arbiter
package ram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_e;

endpackage

// File: rtl/ram_arb_starve.sv
// rtl/ram_arb_starve.sv - saturating wait counter used to stop requester B from starving
module ram_arb_starve
    import ram_arb_pkg::*;
#(
    parameter int CW         = 3,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          inc_i,
    input  logic          clr_i,
    input  logic [CW-1:0] sat_i,
    output logic          ge_max_o
);

    localparam logic [CW-1:0] MAX_C = CW'(STARVE_MAX);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear wins over increment so a grant in the same cycle restarts the wait from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < sat_i)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ge_max_o = (cnt_q >= MAX_C);

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - fixed-priority arbiter (A first) for the shared 256x8 data RAM
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4,
    parameter int CW         = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          a_req_i,
    input  logic          a_we_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [DW-1:0] a_wdata_i,
    output logic          a_ack_o,
    output logic [DW-1:0] a_rdata_o,
    input  logic          b_req_i,
    input  logic          b_we_i,
    input  logic [AW-1:0] b_addr_i,
    input  logic [DW-1:0] b_wdata_i,
    output logic          b_ack_o,
    output logic [DW-1:0] b_rdata_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_data_o,
    output logic          ram_wren_o,
    input  logic [DW-1:0] ram_q_i,
    output logic [1:0]    owner_o,
    output logic          busy_o
);

    localparam int LW = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [LW-1:0] lat_q, lat_d;
    logic          grant_b;
    logic          starve_inc;
    logic          starve_ge;

    assign starve_inc = b_req_i && (owner_q != OWN_B);

    ram_arb_starve #(
        .CW        (CW),
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (starve_inc),
        .clr_i   (grant_b),
        .sat_i   ({CW{1'b1}}),
        .ge_max_o(starve_ge)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lat_d   = lat_q;
        grant_b = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (b_req_i && (!a_req_i || starve_ge)) begin
                    grant_b = 1'b1;
                    owner_d = OWN_B;
                    we_d    = b_we_i;
                    addr_d  = b_addr_i;
                    wdata_d = b_wdata_i;
                    state_d = ST_ISSUE;
                end else if (a_req_i) begin
                    owner_d = OWN_A;
                    we_d    = a_we_i;
                    addr_d  = a_addr_i;
                    wdata_d = a_wdata_i;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // WAIT covers RD_LAT-1 cycles; the counter holds the cycles left after the first.
                if (RD_LAT == 1) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                    lat_d   = LW'(RD_LAT - 2);
                end
            end
            ST_WAIT: begin
                if (lat_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_NONE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lat_q   <= lat_d;
        end
    end

    // Reset gating keeps a write in flight from landing while the arbiter is being aborted.
    assign ram_wren_o = (state_q == ST_ISSUE) && we_q && !rst_i;
    assign ram_addr_o = addr_q;
    assign ram_data_o = wdata_q;
    assign a_ack_o    = (state_q == ST_DONE) && (owner_q == OWN_A) && !rst_i;
    assign b_ack_o    = (state_q == ST_DONE) && (owner_q == OWN_B) && !rst_i;
    assign a_rdata_o  = ram_q_i;
    assign b_rdata_o  = ram_q_i;
    assign owner_o    = owner_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with RD_LAT=1 and RD_LAT=3 instances
module tb_ram_arbiter;

    localparam int SM = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req, a_we, b_req, b_we;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       bd_we, fill;
    logic [7:0] bd_addr, bd_data;

    logic       a_ack1, b_ack1, ram_wren1, busy1;
    logic [7:0] a_rdata1, b_rdata1, ram_addr1, ram_data1, q1;
    logic [1:0] owner1;
    logic       a_ack3, b_ack3, ram_wren3, busy3;
    logic [7:0] a_rdata3, b_rdata3, ram_addr3, ram_data3, q3, s0, s1;
    logic [1:0] owner3;

    logic [7:0] mem1 [256];
    logic [7:0] mem3 [256];

    int n_tot  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.AW(8), .DW(8), .RD_LAT(1), .STARVE_MAX(SM), .CW(3)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_ack_o(a_ack1), .a_rdata_o(a_rdata1),
        .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_ack_o(b_ack1), .b_rdata_o(b_rdata1),
        .ram_addr_o(ram_addr1), .ram_data_o(ram_data1), .ram_wren_o(ram_wren1),
        .ram_q_i(q1), .owner_o(owner1), .busy_o(busy1)
    );

    ram_arbiter #(.AW(8), .DW(8), .RD_LAT(3), .STARVE_MAX(SM), .CW(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst),
        .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_ack_o(a_ack3), .a_rdata_o(a_rdata3),
        .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_ack_o(b_ack3), .b_rdata_o(b_rdata3),
        .ram_addr_o(ram_addr3), .ram_data_o(ram_data3), .ram_wren_o(ram_wren3),
        .ram_q_i(q3), .owner_o(owner3), .busy_o(busy3)
    );

    // RAM models: registered read, one stage for dut1, three stages for dut3
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) mem1[i] <= 8'(i * 37 + 11);
        end else if (bd_we) begin
            mem1[bd_addr] <= bd_data;
        end else if (ram_wren1) begin
            mem1[ram_addr1] <= ram_data1;
        end
        q1 <= mem1[ram_addr1];
    end

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) mem3[i] <= 8'(i * 37 + 11);
        end else if (bd_we) begin
            mem3[bd_addr] <= bd_data;
        end else if (ram_wren3) begin
            mem3[ram_addr3] <= ram_data3;
        end
        s0 <= mem3[ram_addr3];
        s1 <= s0;
        q3 <= s1;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic bd_write(input logic [7:0] ad, input logic [7:0] d);
        bd_we = 1'b1; bd_addr = ad; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic test_reset();
        n_tot++; if (a_ack1 !== 1'b0) $display("FAIL reset_a_ack got=%0b exp=0", a_ack1); else n_pass++;
        n_tot++; if (b_ack1 !== 1'b0) $display("FAIL reset_b_ack got=%0b exp=0", b_ack1); else n_pass++;
        n_tot++; if (ram_wren1 !== 1'b0) $display("FAIL reset_wren got=%0b exp=0", ram_wren1); else n_pass++;
        n_tot++; if (owner1 !== 2'd0) $display("FAIL reset_owner got=%0d exp=0", owner1); else n_pass++;
        n_tot++; if (busy1 !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy1); else n_pass++;
        n_tot++; if (busy3 !== 1'b0) $display("FAIL reset_busy3 got=%0b exp=0", busy3); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_tot++; if (busy1 !== 1'b0) $display("FAIL idle_busy got=%0b exp=0", busy1); else n_pass++;
        n_tot++; if (owner1 !== 2'd0) $display("FAIL idle_owner got=%0d exp=0", owner1); else n_pass++;
    endtask

    task automatic test_a_read();
        do_reset();
        bd_write(8'h10, 8'h5A);
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10; a_wdata = 8'h00;
        @(negedge clk);
        n_tot++; if (ram_addr1 !== 8'h10) $display("FAIL a_read_issue_addr got=%0h exp=10", ram_addr1); else n_pass++;
        n_tot++; if (ram_wren1 !== 1'b0) $display("FAIL a_read_issue_wren got=%0b exp=0", ram_wren1); else n_pass++;
        n_tot++; if (owner1 !== 2'd1) $display("FAIL a_read_owner got=%0d exp=1", owner1); else n_pass++;
        n_tot++; if (a_ack1 !== 1'b0) $display("FAIL a_read_early_ack got=%0b exp=0", a_ack1); else n_pass++;
        @(negedge clk);
        n_tot++; if (a_ack1 !== 1'b1) $display("FAIL a_read_ack got=%0b exp=1", a_ack1); else n_pass++;
        n_tot++; if (a_rdata1 !== 8'h5A) $display("FAIL a_read_data got=%0h exp=5a", a_rdata1); else n_pass++;
        n_tot++; if (b_ack1 !== 1'b0) $display("FAIL a_read_b_ack got=%0b exp=0", b_ack1); else n_pass++;
        a_req = 1'b0;
        @(negedge clk);
        n_tot++; if (a_ack1 !== 1'b0) $display("FAIL a_read_ack_width got=%0b exp=0", a_ack1); else n_pass++;
        n_tot++; if (busy1 !== 1'b0) $display("FAIL a_read_back_idle got=%0b exp=0", busy1); else n_pass++;
    endtask

    task automatic test_b_write_read();
        do_reset();
        b_req = 1'b1; b_we = 1'b1; b_addr = 8'h20; b_wdata = 8'hC3;
        @(negedge clk);
        n_tot++; if (ram_wren1 !== 1'b1) $display("FAIL b_wr_wren got=%0b exp=1", ram_wren1); else n_pass++;
        n_tot++; if (ram_addr1 !== 8'h20) $display("FAIL b_wr_addr got=%0h exp=20", ram_addr1); else n_pass++;
        n_tot++; if (ram_data1 !== 8'hC3) $display("FAIL b_wr_data got=%0h exp=c3", ram_data1); else n_pass++;
        n_tot++; if (owner1 !== 2'd2) $display("FAIL b_wr_owner got=%0d exp=2", owner1); else n_pass++;
        @(negedge clk);
        n_tot++; if (ram_wren1 !== 1'b0) $display("FAIL b_wr_wren_done got=%0b exp=0", ram_wren1); else n_pass++;
        n_tot++; if (b_ack1 !== 1'b1) $display("FAIL b_wr_ack got=%0b exp=1", b_ack1); else n_pass++;
        n_tot++; if (a_ack1 !== 1'b0) $display("FAIL b_wr_a_ack got=%0b exp=0", a_ack1); else n_pass++;
        b_we = 1'b0;
        @(negedge clk);
        n_tot++; if (b_ack1 !== 1'b0 || busy1 !== 1'b0) $display("FAIL b_rd_idle got=%0b%0b exp=00", b_ack1, busy1); else n_pass++;
        @(negedge clk);
        n_tot++; if (ram_wren1 !== 1'b0) $display("FAIL b_rd_wren got=%0b exp=0", ram_wren1); else n_pass++;
        @(negedge clk);
        n_tot++; if (b_ack1 !== 1'b1) $display("FAIL b_rd_ack got=%0b exp=1", b_ack1); else n_pass++;
        n_tot++; if (b_rdata1 !== 8'hC3) $display("FAIL b_rd_data got=%0h exp=c3", b_rdata1); else n_pass++;
        b_req = 1'b0;
    endtask

    task automatic test_starvation();
        logic [12:0] a_mask;
        logic [12:0] b_mask;
        // A served at IDLE 0 and 3 while B's wait climbs past 4; B wins IDLE 6; A again at 9
        a_mask = 13'h0824;
        b_mask = 13'h0100;
        do_reset();
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h40;
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'h41;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n_tot++; if (a_ack1 !== a_mask[k]) $display("FAIL starve_a_ack c%0d got=%0b exp=%0b", k, a_ack1, a_mask[k]); else n_pass++;
            n_tot++; if (b_ack1 !== b_mask[k]) $display("FAIL starve_b_ack c%0d got=%0b exp=%0b", k, b_ack1, b_mask[k]); else n_pass++;
        end
        a_req = 1'b0; b_req = 1'b0;
    endtask

    task automatic test_rd_lat3();
        int wr_pulses;
        do_reset();
        bd_write(8'h50, 8'h96);
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h50;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_tot++; if (a_ack3 !== (k == 4)) $display("FAIL lat3_ack c%0d got=%0b exp=%0b", k, a_ack3, (k == 4)); else n_pass++;
            n_tot++; if (busy3 !== (k <= 4)) $display("FAIL lat3_busy c%0d got=%0b exp=%0b", k, busy3, (k <= 4)); else n_pass++;
            if (k <= 4) begin
                n_tot++; if (ram_addr3 !== 8'h50) $display("FAIL lat3_addr c%0d got=%0h exp=50", k, ram_addr3); else n_pass++;
            end
            if (k == 4) begin
                n_tot++; if (a_rdata3 !== 8'h96) $display("FAIL lat3_data got=%0h exp=96", a_rdata3); else n_pass++;
            end
        end
        a_we = 1'b1; a_addr = 8'h51; a_wdata = 8'h7E;
        wr_pulses = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (ram_wren3 === 1'b1) wr_pulses++;
            n_tot++; if (a_ack3 !== (k == 4)) $display("FAIL lat3_wr_ack c%0d got=%0b exp=%0b", k, a_ack3, (k == 4)); else n_pass++;
            if (k == 4) a_req = 1'b0;
        end
        n_tot++; if (wr_pulses != 1) $display("FAIL lat3_wren_pulses got=%0d exp=1", wr_pulses); else n_pass++;
        n_tot++; if (mem3[8'h51] !== 8'h7E) $display("FAIL lat3_wr_mem got=%0h exp=7e", mem3[8'h51]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bd_write(8'h30, 8'h11);
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'h30; a_wdata = 8'hEE;
        @(negedge clk);
        n_tot++; if (ram_wren1 !== 1'b1) $display("FAIL rstmid_pre_wren got=%0b exp=1", ram_wren1); else n_pass++;
        rst = 1'b1; a_req = 1'b0;
        #1;
        n_tot++; if (ram_wren1 !== 1'b0) $display("FAIL rstmid_gated_wren got=%0b exp=0", ram_wren1); else n_pass++;
        @(negedge clk);
        n_tot++; if (a_ack1 !== 1'b0) $display("FAIL rstmid_ack got=%0b exp=0", a_ack1); else n_pass++;
        n_tot++; if (busy1 !== 1'b0) $display("FAIL rstmid_busy got=%0b exp=0", busy1); else n_pass++;
        n_tot++; if (owner1 !== 2'd0) $display("FAIL rstmid_owner got=%0d exp=0", owner1); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_tot++; if (a_ack1 !== 1'b0) $display("FAIL rstmid_late_ack got=%0b exp=0", a_ack1); else n_pass++;
        n_tot++; if (mem1[8'h30] !== 8'h11) $display("FAIL rstmid_mem got=%0h exp=11", mem1[8'h30]); else n_pass++;
    endtask

    // Transaction-level reference: a grant at IDLE cycle g writes at the end of g+1 and acks in g+1+RD_LAT
    task automatic test_random();
        logic [7:0] mm [256];
        bit         act;
        int         g, cnt, bad;
        logic [1:0] own;
        logic       m_we, e_a, e_b, e_wren;
        logic [7:0] m_ad, m_wd;
        do_reset();
        for (int i = 0; i < 256; i++) mm[i] = mem1[i];
        act = 1'b0; g = 0; cnt = 0; own = 2'd0; m_we = 1'b0; m_ad = 8'h0; m_wd = 8'h0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (!act) begin
                if (b_req && (!a_req || cnt >= SM)) begin
                    act = 1'b1; g = cyc - 1; own = 2'd2; m_we = b_we; m_ad = b_addr; m_wd = b_wdata;
                end else if (a_req) begin
                    act = 1'b1; g = cyc - 1; own = 2'd1; m_we = a_we; m_ad = a_addr; m_wd = a_wdata;
                end
                if (act && own == 2'd2) cnt = 0;
                else if (b_req) cnt = (cnt < 7) ? cnt + 1 : 7;
            end else begin
                if (b_req && own != 2'd2) cnt = (cnt < 7) ? cnt + 1 : 7;
                if (cyc - 1 == g + 1 && m_we) mm[m_ad] = m_wd;
                if (cyc - 1 == g + 2) begin
                    act = 1'b0; own = 2'd0;
                end
            end
            e_a    = act && (cyc == g + 2) && (own == 2'd1);
            e_b    = act && (cyc == g + 2) && (own == 2'd2);
            e_wren = act && (cyc == g + 1) && m_we;
            n_tot++; if (a_ack1 !== e_a) $display("FAIL rnd_a_ack c%0d got=%0b exp=%0b", cyc, a_ack1, e_a); else n_pass++;
            n_tot++; if (b_ack1 !== e_b) $display("FAIL rnd_b_ack c%0d got=%0b exp=%0b", cyc, b_ack1, e_b); else n_pass++;
            n_tot++; if (ram_wren1 !== e_wren) $display("FAIL rnd_wren c%0d got=%0b exp=%0b", cyc, ram_wren1, e_wren); else n_pass++;
            n_tot++; if (owner1 !== own) $display("FAIL rnd_owner c%0d got=%0d exp=%0d", cyc, owner1, own); else n_pass++;
            n_tot++; if (busy1 !== act) $display("FAIL rnd_busy c%0d got=%0b exp=%0b", cyc, busy1, act); else n_pass++;
            if (e_a && !m_we) begin
                n_tot++; if (a_rdata1 !== mm[m_ad]) $display("FAIL rnd_a_rdata c%0d got=%0h exp=%0h", cyc, a_rdata1, mm[m_ad]); else n_pass++;
            end
            if (e_b && !m_we) begin
                n_tot++; if (b_rdata1 !== mm[m_ad]) $display("FAIL rnd_b_rdata c%0d got=%0h exp=%0h", cyc, b_rdata1, mm[m_ad]); else n_pass++;
            end
            if ((!a_req && $urandom_range(0, 3) != 0) || (e_a && $urandom_range(0, 1) == 1)) begin
                a_req = 1'b1; a_we = 1'($urandom_range(0, 1));
                a_addr = 8'(8'h80 + $urandom_range(0, 7)); a_wdata = 8'($urandom);
            end else if (e_a) begin
                a_req = 1'b0;
            end
            if ((!b_req && $urandom_range(0, 2) == 0) || (e_b && $urandom_range(0, 1) == 1)) begin
                b_req = 1'b1; b_we = 1'($urandom_range(0, 1));
                b_addr = 8'(8'h80 + $urandom_range(0, 7)); b_wdata = 8'($urandom);
            end else if (e_b) begin
                b_req = 1'b0;
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        repeat (4) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem1[i] !== mm[i]) bad++;
        n_tot++; if (bad != 0) $display("FAIL rnd_mem_image got=%0d_bad_bytes exp=0", bad); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; fill = 1'b1; bd_we = 1'b0; bd_addr = 8'h0; bd_data = 8'h0;
        a_req = 1'b0; a_we = 1'b0; a_addr = 8'h0; a_wdata = 8'h0;
        b_req = 1'b0; b_we = 1'b0; b_addr = 8'h0; b_wdata = 8'h0;
        repeat (2) @(negedge clk);
        fill = 1'b0;
        test_reset();
        test_a_read();
        test_b_write_read();
        test_starvation();
        test_rd_lat3();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
